// File: rtl/npc_unit.sv
// npc_unit: registered program counter for the single-cycle MIPS datapath.
// Resolves seq/beq/bne/blez/bgtz/j/jr redirects against the current PC.
// A one-entry buffer holds a redirect accepted while stalled.
// A misaligned applied target enters the exception vector and records epc.
module npc_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_4180)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            ctrl_valid,
    output logic            ctrl_ready,
    input  logic [2:0]      br_type,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic [15:0]     imm16,
    input  logic [25:0]     instr_index,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc4,
    output logic            br_taken,
    output logic            exc_pulse,
    output logic [PC_W-1:0] epc
);

    typedef enum logic [2:0] {
        BR_SEQ  = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_J    = 3'd5,
        BR_JR   = 3'd6,
        BR_RSVD = 3'd7
    } br_kind_e;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            exc_q, exc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;

    br_kind_e        br_kind;
    logic            accept;
    logic            cond;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] target;
    logic            apply;
    logic [PC_W-1:0] apply_t;

    assign br_kind    = br_kind_e'(br_type);
    assign ctrl_ready = !pend_valid_q;
    assign accept     = ctrl_valid & ctrl_ready;
    assign pc4        = pc_q + PC_W'(4);
    assign br_off     = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign br_taken   = accept & cond;

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign exc_pulse = exc_q;

    // Decode branch condition and redirect target from the current PC and operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cond   = 1'b0;
        target = pc4 + br_off;
        case (br_kind)
            BR_BEQ:  cond = (rs_val == rt_val);
            BR_BNE:  cond = (rs_val != rt_val);
            BR_BLEZ: cond = rs_val[31] | (rs_val == 32'd0);
            BR_BGTZ: cond = !rs_val[31] & (rs_val != 32'd0);
            BR_J: begin
                cond   = 1'b1;
                target = {pc4[PC_W-1:28], instr_index, 2'b00};
            end
            BR_JR: begin
                cond   = 1'b1;
                target = PC_W'(rs_val);
            end
            default: cond = 1'b0;
        endcase
    end

    // Next-state: buffer under stall, drain the pending entry first, else redirect or step.
    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        exc_d         = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        apply         = 1'b0;
        apply_t       = target;
        if (stall) begin
            if (br_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = target;
            end
        end else if (pend_valid_q) begin
            apply        = 1'b1;
            apply_t      = pend_target_q;
            pend_valid_d = 1'b0;
        end else if (br_taken) begin
            apply = 1'b1;
        end else begin
            pc_d = pc4;
        end
        if (apply) begin
            if (apply_t[1:0] != 2'b00) begin
                pc_d  = EXC_VECTOR;
                epc_d = apply_t;
                exc_d = 1'b1;
            end else begin
                pc_d = apply_t;
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            pc_q          <= RESET_PC;
            epc_q         <= '0;
            exc_q         <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            exc_q         <= exc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed test-plan steps followed by random traffic,
// every cycle compared against a behavioural next-PC model.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, ctrl_valid, ctrl_ready;
    logic [2:0]  br_type;
    logic [31:0] rs_val, rt_val;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] pc, pc4, epc;
    logic        br_taken, exc_pulse;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_epc, m_pt;
    logic        m_pend, m_exc;

    localparam logic [31:0] EXC = 32'h0000_4180;

    npc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready), .br_type(br_type), .rs_val(rs_val), .rt_val(rt_val),
        .imm16(imm16), .instr_index(instr_index), .pc(pc), .pc4(pc4),
        .br_taken(br_taken), .exc_pulse(exc_pulse), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
        case (t)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return $signed(rs) <= 0;
            3'd4: return $signed(rs) > 0;
            3'd5, 3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [2:0] t, input logic [31:0] cur);
        int signed off;
        off = $signed(imm16) * 4;
        case (t)
            3'd5: return ((cur + 32'd4) & 32'hF000_0000) | ({6'd0, instr_index} * 4);
            3'd6: return rs_val;
            default: return cur + 32'd4 + 32'(off);
        endcase
    endfunction

    task automatic model_apply(input logic [31:0] t);
        if (t % 4 != 0) begin
            m_pc = EXC; m_epc = t; m_exc = 1'b1;
        end else begin
            m_pc = t; m_exc = 1'b0;
        end
    endtask

    // One clock: inputs already driven at negedge; check, clock, advance model.
    task automatic cycle();
        logic taken;
        logic [31:0] tgt;
        #1;
        taken = ctrl_valid && !m_pend && model_cond(br_type, rs_val, rt_val);
        tgt   = model_target(br_type, m_pc);
        check("pc", pc, m_pc);
        check("pc4", pc4, m_pc + 32'd4);
        check("ctrl_ready", {31'd0, ctrl_ready}, {31'd0, !m_pend});
        check("br_taken", {31'd0, br_taken}, {31'd0, taken});
        check("exc_pulse", {31'd0, exc_pulse}, {31'd0, m_exc});
        check("epc", epc, m_epc);
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h3000; m_epc = 0; m_pt = 0; m_pend = 0; m_exc = 0;
        end else if (stall) begin
            m_exc = 1'b0;
            if (taken) begin m_pend = 1'b1; m_pt = tgt; end
        end else if (m_pend) begin
            model_apply(m_pt); m_pend = 1'b0;
        end else if (taken) begin
            model_apply(tgt);
        end else begin
            m_pc = m_pc + 32'd4; m_exc = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic v, input logic [2:0] t,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [25:0] idx);
        stall = s; ctrl_valid = v; br_type = t; rs_val = rs; rt_val = rt;
        imm16 = imm; instr_index = idx;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 3'd0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        m_pc = 32'h3000; m_epc = 0; m_pt = 0; m_pend = 0; m_exc = 0;
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch after reset
        check("reset_pc", pc, 32'h3000);
        cycle(); cycle();
        check("seq_pc", pc, 32'h3008);

        // Branch conditions
        drive(0, 1, 3'd1, 5, 5, 16'hFFFF, 0); cycle();
        check("beq_taken", pc, 32'h3008);
        drive(0, 1, 3'd2, 5, 5, 16'hFFFF, 0); cycle();
        check("bne_not_taken", pc, 32'h300C);
        drive(0, 1, 3'd4, 0, 0, 16'h0010, 0); cycle();
        check("bgtz_zero", pc, 32'h3010);
        drive(0, 1, 3'd3, 32'h8000_0000, 0, 16'hFFFF, 0); cycle();
        check("blez_neg", pc, 32'h3010);

        // Jump
        drive(0, 1, 3'd5, 0, 0, 0, 26'h0000C10); #1;
        check("j_br_taken", {31'd0, br_taken}, 32'd1);
        cycle();
        check("j_target", pc, 32'h3040);

        // Buffered jr, second request ignored while pending
        drive(1, 1, 3'd6, 32'h3100, 0, 0, 0); cycle();
        check("buf_hold", pc, 32'h3040);
        check("buf_ready", {31'd0, ctrl_ready}, 32'd0);
        drive(1, 1, 3'd5, 0, 0, 0, 26'h0000100); cycle(); cycle();
        check("buf_hold2", pc, 32'h3040);
        drive(0, 0, 3'd0, 0, 0, 0, 0); cycle();
        check("buf_apply", pc, 32'h3100);
        check("buf_ready_back", {31'd0, ctrl_ready}, 32'd1);

        // Misaligned jr -> exception
        drive(0, 1, 3'd6, 32'h3102, 0, 0, 0); cycle();
        check("exc_pc", pc, EXC);
        check("exc_pulse_hi", {31'd0, exc_pulse}, 32'd1);
        check("exc_epc", epc, 32'h3102);
        drive(0, 0, 3'd0, 0, 0, 0, 0); cycle();
        check("exc_next", pc, 32'h4184);
        check("exc_pulse_lo", {31'd0, exc_pulse}, 32'd0);

        // Reset discards a pending redirect
        drive(1, 1, 3'd6, 32'h3100, 0, 0, 0); cycle();
        drive(1, 0, 3'd0, 0, 0, 0, 0); reset = 1'b1; cycle();
        reset = 1'b0;
        check("rst_pc", pc, 32'h3000);
        check("rst_ready", {31'd0, ctrl_ready}, 32'd1);
        cycle();
        drive(0, 0, 3'd0, 0, 0, 0, 0); cycle();
        check("rst_no_pending", pc, 32'h3004);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(1) == 1) ? $urandom : (m_pc + 32'(4 * $urandom_range(8)) + 32'($urandom_range(3)));
            if ($urandom_range(3) == 0) rs = 32'($urandom_range(2)) - 32'd1;
            drive($urandom_range(3) == 0, 1'($urandom_range(1)), 3'($urandom_range(7)), rs,
                  ($urandom_range(1) == 1) ? rs : $urandom, 16'($urandom), 26'($urandom));
            reset = ($urandom_range(99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
